// File: rtl/hwpe_vfpu_job_fsm.sv
// Job-level controller of the HWPE vector FPU: latches job setup, triggers the streamers,
// gates and counts operand issue / result retirement, accumulates FPU flags and signals done.
// Optional no-progress watchdog enabled by defining HWPE_VFPU_WATCHDOG_EN.
module hwpe_vfpu_job_fsm #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned WDOG_WIDTH = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] trans_size_i,
  input  logic [2:0]           operation_i,
  input  logic [1:0]           rounding_mode_i,
  input  logic                 streams_ready_i,
  output logic                 stream_req_o,
  output logic                 fpu_en_o,
  input  logic                 fpu_in_fire_i,
  input  logic                 fpu_out_fire_i,
  input  logic [5:0]           flags_i,
  input  logic                 sink_done_i,
  output logic [4:0]           ctrl_vfpu_o,
  output logic [5:0]           flags_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  typedef enum logic [2:0] {IDLE, START, COMPUTE, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [2:0] operation;
    logic [1:0] rounding_mode;
  } ctrl_vfpu_t;

  typedef logic [5:0] flags_vfpu_t;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  size_q, size_d;
  logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
  ctrl_vfpu_t            ctrl_q, ctrl_d;
  flags_vfpu_t           flags_q, flags_d;
  logic                  fpu_en_q, fpu_en_d;

  logic in_job;
  logic in_count;
  logic out_count;
  logic issue_last;
  logic drain_exit;
  logic wdog_expired;
  logic abort;

  // Fires beyond the job size, or operands offered while issue is gated, are dropped here.
  assign in_job     = (state_q == COMPUTE) || (state_q == DRAIN);
  assign in_count   = fpu_in_fire_i && fpu_en_q && (issue_cnt_q < size_q);
  assign out_count  = fpu_out_fire_i && in_job && (res_cnt_q < size_q);
  assign issue_last = in_count && ((issue_cnt_q + CNT_WIDTH'(1)) == size_q);
  assign drain_exit = (state_q == DRAIN) && (res_cnt_q == size_q) && sink_done_i;
  assign abort      = wdog_expired && !drain_exit;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      size_q      <= '0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      ctrl_q      <= '0;
      flags_q     <= '0;
      fpu_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      ctrl_q      <= ctrl_d;
      flags_q     <= flags_d;
      fpu_en_q    <= fpu_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (trans_size_i == '0) ? DONE : START;
      START:   if (streams_ready_i) state_d = COMPUTE;
      COMPUTE: begin
        if (abort)           state_d = DONE;
        else if (issue_last) state_d = DRAIN;
      end
      DRAIN:   if (drain_exit || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Job setup latches, element counters and sticky flags
  // ---------------------------------------------------------------------------
  always_comb begin
    size_d      = size_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    ctrl_d      = ctrl_q;
    flags_d     = flags_q;
    if (clear_i) begin
      size_d      = '0;
      issue_cnt_d = '0;
      res_cnt_d   = '0;
      ctrl_d      = '0;
      flags_d     = '0;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        size_d      = trans_size_i;
        ctrl_d      = '{operation: operation_i, rounding_mode: rounding_mode_i};
        flags_d     = '0;
        issue_cnt_d = '0;
        res_cnt_d   = '0;
      end
      if (in_count) issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
      if (out_count) begin
        res_cnt_d = res_cnt_q + CNT_WIDTH'(1);
        flags_d   = flags_q | flags_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state, except the registered issue enable
  // ---------------------------------------------------------------------------
  always_comb begin
    fpu_en_d     = (state_d == COMPUTE) && (issue_cnt_d < size_q);
    fpu_en_o     = fpu_en_q;
    busy_o       = (state_q != IDLE);
    stream_req_o = (state_q == START);
    done_o       = (state_q == DONE);
    ctrl_vfpu_o  = ctrl_q;
    flags_o      = flags_q;
  end

`ifdef HWPE_VFPU_WATCHDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic                  sink_done_q;
  logic                  error_q, error_d;

  // Any sign of progress restarts the count; outside an active job it is held at zero.
  always_comb begin
    wdog_d  = wdog_q + WDOG_WIDTH'(1);
    error_d = error_q;
    if (!in_job || clear_i || in_count || out_count || (sink_done_i && !sink_done_q)) begin
      wdog_d = '0;
    end
    if (clear_i || ((state_q == IDLE) && start_i)) error_d = 1'b0;
    else if (abort)                                error_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q      <= '0;
      sink_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      sink_done_q <= sink_done_i;
      error_q     <= error_d;
    end
  end

  assign wdog_expired = in_job && (&wdog_q);
  assign error_o      = error_q;
`else
  logic [WDOG_WIDTH-1:0] unused_wdog;
  assign unused_wdog  = '0;
  assign wdog_expired = 1'b0;
  assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_hwpe_vfpu_job_fsm.sv
// Scoreboard bench for hwpe_vfpu_job_fsm: directed jobs push expected completions,
// a monitor pops and compares them whenever done_o pulses.
module tb_hwpe_vfpu_job_fsm;
  localparam int CW = 16;
  localparam int WW = 12;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] trans_size_i = '0;
  logic [2:0]    operation_i = '0;
  logic [1:0]    rounding_mode_i = '0;
  logic          streams_ready_i = 1'b1;
  logic          stream_req_o;
  logic          fpu_en_o;
  logic          fpu_in_fire_i = 1'b0;
  logic          fpu_out_fire_i = 1'b0;
  logic [5:0]    flags_i = '0;
  logic          sink_done_i = 1'b1;
  logic [4:0]    ctrl_vfpu_o;
  logic [5:0]    flags_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  hwpe_vfpu_job_fsm #(.CNT_WIDTH(CW), .WDOG_WIDTH(WW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .trans_size_i(trans_size_i), .operation_i(operation_i), .rounding_mode_i(rounding_mode_i),
    .streams_ready_i(streams_ready_i), .stream_req_o(stream_req_o), .fpu_en_o(fpu_en_o),
    .fpu_in_fire_i(fpu_in_fire_i), .fpu_out_fire_i(fpu_out_fire_i), .flags_i(flags_i),
    .sink_done_i(sink_done_i), .ctrl_vfpu_o(ctrl_vfpu_o), .flags_o(flags_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         latency;
    logic [4:0] ctrl;
    logic [5:0] flags;
    logic       err;
    bit         chk_payload;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] flag_tab[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         in_fire_cnt = 0;
  bit         req_seen = 1'b0;
  bit         auto_fire = 1'b1;
  bit         force_fire = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FPU/streamer model: operands accepted whenever issue is enabled, results one cycle later.
  initial forever begin
    @(negedge clk_i);
    fpu_out_fire_i = fpu_in_fire_i;
    flags_i = (fpu_out_fire_i && flag_tab.size() > 0) ? flag_tab.pop_front() : 6'b0;
    fpu_in_fire_i = force_fire ? busy_o : (auto_fire && fpu_en_o);
    if (fpu_in_fire_i) in_fire_cnt++;
  end

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (stream_req_o) req_seen = 1'b1;
      if (done_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check("done_latency", cyc - start_cyc, e.latency);
          if (e.chk_payload) begin
            check("ctrl_vfpu_o", ctrl_vfpu_o, e.ctrl);
            check("flags_o", flags_o, e.flags);
          end
          check("error_o", error_o, e.err);
        end
      end
    end
  end

  task automatic start_job(input int size, input logic [2:0] op, input logic [1:0] rnd);
    @(negedge clk_i);
    trans_size_i    = CW'(size);
    operation_i     = op;
    rounding_mode_i = rnd;
    start_i         = 1'b1;
    start_cyc       = cyc;
    req_seen        = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_job(input int size, input logic [2:0] op, input logic [1:0] rnd,
                         input int lat, input logic [5:0] flg, input logic err, input bit chk);
    exp_t e;
    e.latency = lat; e.ctrl = {op, rnd}; e.flags = flg; e.err = err; e.chk_payload = chk;
    sb_q.push_back(e);
    start_job(size, op, rnd);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      #1;
      if (sb_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done_o within %0d cycles expected completion", budget);
    sb_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_stream_req"}, stream_req_o, 1'b0);
    check({tag, "_fpu_en"}, fpu_en_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_error"}, error_o, 1'b0);
    check({tag, "_ctrl"}, ctrl_vfpu_o, 5'b0);
    check({tag, "_flags"}, flags_o, 6'b0);
  endtask

  initial begin : stimulus
    int req_cnt;
    int en_cnt;
    repeat (3) @(negedge clk_i);
    check_idle("reset");
    rst_ni = 1'b1;

    // size 4, op 2, rnd 1: ctrl 01001, 4 accepted operands, done 8 cycles after start
    in_fire_cnt = 0;
    run_job(4, 3'd2, 2'd1, 8, 6'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    start_i = 1'b1; trans_size_i = 16'd7; operation_i = 3'd7; rounding_mode_i = 2'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(60);
    check("in_fires_size4", in_fire_cnt, 4);

    // flags accumulate over results 1 and 3
    flag_tab = '{6'b000100, 6'b000000, 6'b100000};
    run_job(3, 3'd5, 2'd3, 7, 6'b100100, 1'b0, 1'b1);
    wait_done(60);

    // zero-size job: done the next cycle, no stream request
    run_job(0, 3'd1, 2'd0, 1, 6'b0, 1'b0, 1'b0);
    wait_done(20);
    check("zero_size_no_req", req_seen, 1'b0);

    // surplus and ungated fires are ignored; results beyond size carry flags that must not stick
    flag_tab = '{6'b000000, 6'b000000, 6'b000001};
    force_fire = 1'b1;
    run_job(2, 3'd0, 2'd2, 5, 6'b0, 1'b0, 1'b1);
    wait_done(60);
    force_fire = 1'b0;
    flag_tab.delete();
    repeat (3) @(negedge clk_i);

    // streamers busy for 10 cycles: request held, issue stays gated
    streams_ready_i = 1'b0;
    run_job(2, 3'd3, 2'd0, 15, 6'b0, 1'b0, 1'b1);
    req_cnt = 0;
    en_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk_i);
      req_cnt += int'(stream_req_o);
      en_cnt  += int'(fpu_en_o);
    end
    streams_ready_i = 1'b1;
    @(negedge clk_i);
    check("req_dropped_after_hs", stream_req_o, 1'b0);
    check("fpu_en_after_hs", fpu_en_o, 1'b1);
    wait_done(60);
    check("req_held_cycles", req_cnt, 10);
    check("fpu_en_while_waiting", en_cnt, 0);

    // asynchronous reset in the middle of COMPUTE, then a normal size-1 job
    start_job(8, 3'd6, 2'd2);
    repeat (3) @(negedge clk_i);
    check("pre_reset_fpu_en", fpu_en_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_job(1, 3'd4, 2'd3, 5, 6'b0, 1'b0, 1'b1);
    wait_done(60);

    // clear while draining: back to idle with everything zeroed and no completion
    sink_done_i = 1'b0;
    flag_tab = '{6'b000010, 6'b001000};
    start_job(2, 3'd6, 2'd1);
    repeat (5) @(negedge clk_i);
    check("drain_busy", busy_o, 1'b1);
    check("drain_fpu_en", fpu_en_o, 1'b0);
    check("drain_flags", flags_o, 6'b001010);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check_idle("clear");
    repeat (5) @(negedge clk_i);
    sink_done_i = 1'b1;

`ifdef HWPE_VFPU_WATCHDOG_EN
    // last progress at the result retiring 4 cycles after start; counter then needs 4096 edges
    sink_done_i = 1'b0;
    run_job(1, 3'd0, 2'd0, 4100, 6'b0, 1'b1, 1'b1);
    wait_done(5000);
    check("error_sticky", error_o, 1'b1);
    sink_done_i = 1'b1;
    run_job(1, 3'd2, 2'd2, 5, 6'b0, 1'b0, 1'b1);
    wait_done(60);
`endif

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
